// File: rtl/app_host_pkg.sv
// app_host_pkg: shared definitions for the app byte-protocol host.
// Holds command codes, the escape byte, the CRC32 and LFSR polynomials,
// the host FSM state type and the byte-level helper functions used by
// the host FSM (app_host) and its LFSR/CRC generator (app_host_gen).
package app_host_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 24;

  localparam logic [7:0] ESC            = 8'h00;
  localparam logic [7:0] CMD_IN         = 8'd1;
  localparam logic [7:0] CMD_OUT        = 8'd2;
  localparam logic [7:0] CMD_WAIT       = 8'd3;
  localparam logic [7:0] CMD_LFSR_WRITE = 8'd4;
  localparam logic [7:0] CMD_LFSR_READ  = 8'd5;
  localparam logic [7:0] CMD_ROM_READ   = 8'd6;
  localparam logic [7:0] CMD_RAM_READ   = 8'd7;

  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
  localparam logic [23:0] LFSR_POLY = 24'hE10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TX_DATA,
    ST_RX_DATA,
    ST_RX_CHECK
  } state_t;

  // MSB-first register, data bits fed LSB-first: the byte-serial form of
  // the reflected CRC-32 without the bit reversal of the register.
  function automatic logic [31:0] crc32(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  function automatic logic [23:0] lfsr_next(input logic [23:0] l);
    return {l[22:0], ~^(l & LFSR_POLY)};
  endfunction

  // Index of the last header byte (index 0 is ESC, index 1 the command).
  function automatic logic [2:0] hdr_last(input logic [7:0] cmd);
    case (cmd)
      CMD_IN, CMD_OUT, CMD_LFSR_WRITE, CMD_ROM_READ, CMD_RAM_READ: return 3'd4;
      CMD_WAIT: return 3'd2;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [7:0]  cmd,
                                          input logic [23:0] len,
                                          input logic [7:0]  wt,
                                          input logic [23:0] seed,
                                          input logic [2:0]  idx);
    logic [23:0] arg;
    arg = (cmd == CMD_LFSR_WRITE) ? seed : len;
    case (idx)
      3'd1:    return cmd;
      3'd2:    return (cmd == CMD_WAIT) ? wt : arg[7:0];
      3'd3:    return arg[15:8];
      3'd4:    return arg[23:16];
      default: return ESC;
    endcase
  endfunction

endpackage

// File: rtl/app_host_if.sv
// app_host_if: byte streams between the host and the app.
//   out_data/out_valid/out_ready : host -> app OUT stream
//   in_data/in_valid/in_ready    : app -> host IN stream
// A byte moves on a clock edge where valid and ready are both high.
// master = host side, slave = app side.
interface app_host_if;
  import app_host_pkg::*;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  modport slave (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );

endinterface

// File: rtl/app_host_gen.sv
// app_host_gen: LFSR payload source and CRC32 accumulator.
//   clk_i, rstn_i  clock, async active-low reset
//   init_i         load lfsr_o <= seed_i and crc_o <= all ones
//   seed_i         LFSR seed
//   lfsr_step_i    advance the LFSR one byte step
//   crc_step_i     fold crc_byte_i into the CRC
//   crc_byte_i     byte to accumulate
//   lfsr_o         current LFSR state (payload byte is lfsr_o[7:0])
//   crc_o          running CRC32, un-inverted
module app_host_gen
  import app_host_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              init_i,
  input  logic [LEN_W-1:0]  seed_i,
  input  logic              lfsr_step_i,
  input  logic              crc_step_i,
  input  logic [DATA_W-1:0] crc_byte_i,
  output logic [LEN_W-1:0]  lfsr_o,
  output logic [31:0]       crc_o
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_o <= '0;
      crc_o  <= '1;
    end else if (init_i) begin
      lfsr_o <= seed_i;
      crc_o  <= '1;
    end else begin
      if (lfsr_step_i) lfsr_o <= lfsr_next(lfsr_o);
      if (crc_step_i)  crc_o  <= crc32(crc_byte_i, crc_o);
    end
  end

endmodule

// File: rtl/app_host.sv
// app_host: command initiator for the app byte protocol.
// Sends ESC, command and argument bytes on the OUT stream, sources LFSR
// payload (OUT), sinks IN data, and checks the 4-byte CRC32 / LFSR
// readback before reporting pass/fail.
//   clk_i, rstn_i       clock, async active-low reset
//   start_i             launch a command when busy_o=0
//   cmd_i, len_i        command code, byte count minus 1
//   wait_i, seed_i      WAIT argument, LFSR seed / LFSR_READ expected value
//   bus (master)        out_data/out_valid/out_ready, in_data/in_valid/in_ready
//   busy_o, done_o      command in progress, one-cycle end pulse
//   pass_o, timeout_o   result of last command, held until next start
//   crc_o               running CRC32 of the last payload (un-inverted)
// TIMEOUT: idle cycles allowed while waiting on in_valid; 0 disables.
module app_host
  import app_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [7:0]        cmd_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [7:0]        wait_i,
  input  logic [LEN_W-1:0]  seed_i,
  app_host_if.master        bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [31:0]       crc_o
);

  state_t            state;
  logic [7:0]        cmd_q;
  logic [7:0]        wait_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  seed_q;
  logic [LEN_W-1:0]  cnt;
  logic [2:0]        hidx;
  logic [1:0]        cidx;
  logic              err;
  logic [15:0]       tmo;
  logic [LEN_W-1:0]  lfsr;
  logic [LEN_W-1:0]  lfsr_nxt;
  logic [7:0]        exp_byte;
  logic              out_fire;
  logic              in_fire;
  logic              rx_state;
  logic              tmo_hit;
  logic              mismatch;
  logic              gen_init;
  logic              lfsr_step;
  logic              crc_step;

  assign rx_state     = (state == ST_RX_DATA) || (state == ST_RX_CHECK);
  assign bus.in_ready = rx_state;
  assign out_fire     = bus.out_valid & bus.out_ready;
  assign in_fire      = bus.in_valid & rx_state;
  assign lfsr_nxt     = lfsr_next(lfsr);
  assign tmo_hit      = (TIMEOUT != 0) && ({16'd0, tmo} == TIMEOUT - 32'd1);
  assign mismatch     = (bus.in_data != exp_byte);

  assign gen_init  = (state == ST_IDLE) && start_i;
  assign lfsr_step = (state == ST_TX_DATA) && out_fire;
  assign crc_step  = lfsr_step || ((state == ST_RX_DATA) && in_fire);

  app_host_gen u_gen (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .init_i      (gen_init),
    .seed_i      (seed_i),
    .lfsr_step_i (lfsr_step),
    .crc_step_i  (crc_step),
    .crc_byte_i  ((state == ST_TX_DATA) ? lfsr[7:0] : bus.in_data),
    .lfsr_o      (lfsr),
    .crc_o       (crc_o)
  );

  // Readback bytes: CRC is sent as the standard (reflected, inverted)
  // CRC32, least significant byte first.
  always_comb begin
    exp_byte = 8'h00;
    if (cmd_q == CMD_LFSR_READ) begin
      case (cidx)
        2'd0:    exp_byte = seed_q[7:0];
        2'd1:    exp_byte = seed_q[15:8];
        2'd2:    exp_byte = seed_q[23:16];
        default: exp_byte = 8'h00;
      endcase
    end else begin
      case (cidx)
        2'd0:    exp_byte = rev8(~crc_o[31:24]);
        2'd1:    exp_byte = rev8(~crc_o[23:16]);
        2'd2:    exp_byte = rev8(~crc_o[15:8]);
        default: exp_byte = rev8(~crc_o[7:0]);
      endcase
    end
  end

  // Command arguments are pure data, captured once per start.
  always_ff @(posedge clk_i) begin
    if (gen_init) begin
      cmd_q  <= cmd_i;
      len_q  <= len_i;
      wait_q <= wait_i;
      seed_q <= seed_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= ST_IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      timeout_o     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      cnt           <= '0;
      hidx          <= '0;
      cidx          <= '0;
      err           <= 1'b0;
      tmo           <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state         <= ST_HDR;
            busy_o        <= 1'b1;
            pass_o        <= 1'b0;
            timeout_o     <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= ESC;
            cnt           <= len_i;
            hidx          <= '0;
            cidx          <= '0;
            err           <= 1'b0;
            tmo           <= '0;
          end
        end
        ST_HDR: begin
          if (out_fire) begin
            if (hidx == hdr_last(cmd_q)) begin
              case (cmd_q)
                CMD_IN, CMD_ROM_READ, CMD_RAM_READ: begin
                  state         <= ST_RX_DATA;
                  bus.out_valid <= 1'b0;
                end
                CMD_OUT: begin
                  state        <= ST_TX_DATA;
                  bus.out_data <= lfsr[7:0];
                end
                CMD_LFSR_READ: begin
                  state         <= ST_RX_CHECK;
                  bus.out_valid <= 1'b0;
                end
                default: begin
                  // WAIT/LFSR_WRITE complete here; an unknown code leaves
                  // the app in loopback, so it is reported as a failure.
                  state         <= ST_IDLE;
                  busy_o        <= 1'b0;
                  done_o        <= 1'b1;
                  pass_o        <= (cmd_q == CMD_WAIT) || (cmd_q == CMD_LFSR_WRITE);
                  bus.out_valid <= 1'b0;
                end
              endcase
            end else begin
              hidx         <= hidx + 3'd1;
              bus.out_data <= hdr_byte(cmd_q, len_q, wait_q, seed_q, hidx + 3'd1);
            end
          end
        end
        ST_TX_DATA: begin
          if (out_fire) begin
            if (cnt == '0) begin
              state         <= ST_RX_CHECK;
              bus.out_valid <= 1'b0;
            end else begin
              cnt          <= cnt - 24'd1;
              bus.out_data <= lfsr_nxt[7:0];
            end
          end
        end
        ST_RX_DATA, ST_RX_CHECK: begin
          if (in_fire) begin
            tmo <= '0;
            if (state == ST_RX_DATA) begin
              if (cnt != '0) begin
                cnt <= cnt - 24'd1;
              end else if (cmd_q == CMD_IN) begin
                state <= ST_RX_CHECK;
              end else begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= 1'b1;
              end
            end else begin
              // All four bytes are consumed even after a mismatch so the
              // stream stays byte-aligned with the app.
              cidx <= cidx + 2'd1;
              err  <= err | mismatch;
              if (cidx == 2'd3) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= ~(err | mismatch);
              end
            end
          end else if (tmo_hit) begin
            state     <= ST_IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            pass_o    <= 1'b0;
            timeout_o <= 1'b1;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_app_host.sv
module tb_app_host;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  cmd;
  logic [23:0] len;
  logic [7:0]  wt;
  logic [23:0] seed;
  logic        busy, done, pass, tmo;
  logic [31:0] crc;

  app_host_if bus();

  app_host #(.TIMEOUT(16)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .start_i   (start),
    .cmd_i     (cmd),
    .len_i     (len),
    .wait_i    (wt),
    .seed_i    (seed),
    .bus       (bus),
    .busy_o    (busy),
    .done_o    (done),
    .pass_o    (pass),
    .timeout_o (tmo),
    .crc_o     (crc)
  );

  int checks   = 0;
  int failures = 0;
  int rdy_seen  = 0;
  int done_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.in_ready === 1'b1) rdy_seen++;
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reflected CRC-32 (poly EDB88320), register not inverted.
  function automatic logic [31:0] crc_ref(input logic [31:0] r, input logic [7:0] d);
    logic [31:0] x;
    logic        fb;
    x = r;
    for (int i = 0; i < 8; i++) begin
      fb = x[0] ^ d[i];
      x  = x >> 1;
      if (fb) x = x ^ 32'hEDB88320;
    end
    return x;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic do_start(input logic [7:0] c, input logic [23:0] l,
                          input logic [7:0] w, input logic [23:0] s);
    cmd = c; len = l; wt = w; seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.out_valid}, 32'd1);
    if (bus.out_valid === 1'b1) begin
      check(tag, {24'd0, bus.out_data}, {24'd0, exp});
      @(negedge clk);
    end
  endtask

  task automatic put_in(input string tag, input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) check(tag, {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  logic [31:0] r;
  logic [31:0] f;
  logic [7:0]  pay [256];
  logic [7:0]  str [9];
  int          n;
  int          snap;

  initial begin
    rstn = 1'b0; start = 1'b0; cmd = '0; len = '0; wt = '0; seed = '0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);

    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_done",     {31'd0, done}, 32'd0);
    check("rst_pass",     {31'd0, pass}, 32'd0);
    check("rst_timeout",  {31'd0, tmo}, 32'd0);
    check("rst_outvalid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_outdata",  {24'd0, bus.out_data}, 32'd0);
    check("rst_inready",  {31'd0, bus.in_ready}, 32'd0);
    check("rst_crc",      crc, 32'hFFFFFFFF);
    rstn = 1'b1;
    @(negedge clk);

    // WAIT
    snap = rdy_seen;
    do_start(8'd3, 24'd0, 8'h05, 24'd0);
    check("wait_busy", {31'd0, busy}, 32'd1);
    expect_out("wait_b0", 8'h00);
    expect_out("wait_b1", 8'h03);
    expect_out("wait_b2", 8'h05);
    wait_done("wait_done");
    check("wait_pass", {31'd0, pass}, 32'd1);
    check("wait_notbusy", {31'd0, busy}, 32'd0);
    check("wait_no_inready", rdy_seen - snap, 32'd0);
    @(negedge clk);
    check("wait_done_pulse", {31'd0, done}, 32'd0);
    check("wait_pass_held", {31'd0, pass}, 32'd1);

    // OUT len=3 seed=0, with an ignored start mid-header
    do_start(8'd2, 24'd3, 8'd0, 24'd0);
    check("out_pass_cleared", {31'd0, pass}, 32'd0);
    cmd = 8'd3; start = 1'b1;
    expect_out("out_h0", 8'h00);
    start = 1'b0;
    expect_out("out_h1", 8'h02);
    expect_out("out_h2", 8'h03);
    expect_out("out_h3", 8'h00);
    expect_out("out_h4", 8'h00);
    expect_out("out_d0", 8'h00);
    expect_out("out_d1", 8'h01);
    expect_out("out_d2", 8'h03);
    expect_out("out_d3", 8'h07);
    r = 32'hFFFFFFFF;
    r = crc_ref(r, 8'h00); r = crc_ref(r, 8'h01);
    r = crc_ref(r, 8'h03); r = crc_ref(r, 8'h07);
    f = ~r;
    put_in("out_c0", f[7:0]);
    put_in("out_c1", f[15:8]);
    put_in("out_c2", f[23:16]);
    put_in("out_c3", f[31:24]);
    wait_done("out_done");
    check("out_pass", {31'd0, pass}, 32'd1);
    check("out_crc", crc, rev32(r));

    // IN len=8 with "123456789": known CRC32 CBF43926
    for (int i = 0; i < 9; i++) str[i] = 8'h31 + 8'(i);
    do_start(8'd1, 24'd8, 8'd0, 24'd0);
    expect_out("in9_h0", 8'h00);
    expect_out("in9_h1", 8'h01);
    expect_out("in9_h2", 8'h08);
    expect_out("in9_h3", 8'h00);
    expect_out("in9_h4", 8'h00);
    for (int i = 0; i < 9; i++) put_in("in9_d", str[i]);
    put_in("in9_c0", 8'h26);
    put_in("in9_c1", 8'h39);
    put_in("in9_c2", 8'hF4);
    put_in("in9_c3", 8'hCB);
    wait_done("in9_done");
    check("in9_pass", {31'd0, pass}, 32'd1);
    check("in9_crc", crc, rev32(~32'hCBF43926));

    // Same, first CRC byte flipped
    do_start(8'd1, 24'd8, 8'd0, 24'd0);
    for (int i = 0; i < 5; i++) expect_out("in9f_h", (i == 1) ? 8'h01 : ((i == 2) ? 8'h08 : 8'h00));
    for (int i = 0; i < 9; i++) put_in("in9f_d", str[i]);
    put_in("in9f_c0", 8'h27);
    put_in("in9f_c1", 8'h39);
    put_in("in9f_c2", 8'hF4);
    check("in9f_not_done_early", {31'd0, done}, 32'd0);
    check("in9f_still_ready", {31'd0, bus.in_ready}, 32'd1);
    put_in("in9f_c3", 8'hCB);
    wait_done("in9f_done");
    check("in9f_pass", {31'd0, pass}, 32'd0);
    check("in9f_timeout", {31'd0, tmo}, 32'd0);

    // IN len=255
    r = 32'hFFFFFFFF;
    for (int i = 0; i < 256; i++) begin
      pay[i] = 8'(i * 13 + 5);
      r = crc_ref(r, pay[i]);
    end
    f = ~r;
    do_start(8'd1, 24'd255, 8'd0, 24'd0);
    expect_out("in256_h0", 8'h00);
    expect_out("in256_h1", 8'h01);
    expect_out("in256_h2", 8'hFF);
    expect_out("in256_h3", 8'h00);
    expect_out("in256_h4", 8'h00);
    for (int i = 0; i < 256; i++) put_in("in256_d", pay[i]);
    put_in("in256_c0", f[7:0]);
    put_in("in256_c1", f[15:8]);
    put_in("in256_c2", f[23:16]);
    put_in("in256_c3", f[31:24]);
    wait_done("in256_done");
    check("in256_pass", {31'd0, pass}, 32'd1);
    check("in256_crc", crc, rev32(r));

    // LFSR_WRITE then LFSR_READ
    do_start(8'd4, 24'd0, 8'd0, 24'h123456);
    expect_out("lw_b0", 8'h00);
    expect_out("lw_b1", 8'h04);
    expect_out("lw_b2", 8'h56);
    expect_out("lw_b3", 8'h34);
    expect_out("lw_b4", 8'h12);
    wait_done("lw_done");
    check("lw_pass", {31'd0, pass}, 32'd1);
    do_start(8'd5, 24'd0, 8'd0, 24'h123456);
    expect_out("lr_b0", 8'h00);
    expect_out("lr_b1", 8'h05);
    put_in("lr_r0", 8'h56);
    put_in("lr_r1", 8'h34);
    put_in("lr_r2", 8'h12);
    put_in("lr_r3", 8'h00);
    wait_done("lr_done");
    check("lr_pass", {31'd0, pass}, 32'd1);

    // Unknown command
    do_start(8'd9, 24'd0, 8'd0, 24'd0);
    expect_out("unk_b0", 8'h00);
    expect_out("unk_b1", 8'h09);
    wait_done("unk_done");
    check("unk_pass", {31'd0, pass}, 32'd0);
    check("unk_timeout", {31'd0, tmo}, 32'd0);

    // RAM_READ with silent responder: timeout after 16 idle cycles
    do_start(8'd7, 24'd4, 8'd0, 24'd0);
    expect_out("ram_h0", 8'h00);
    expect_out("ram_h1", 8'h07);
    expect_out("ram_h2", 8'h04);
    expect_out("ram_h3", 8'h00);
    expect_out("ram_h4", 8'h00);
    check("ram_inready", {31'd0, bus.in_ready}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ram_tmo_cycles", n, 32'd16);
    check("ram_timeout", {31'd0, tmo}, 32'd1);
    check("ram_pass", {31'd0, pass}, 32'd0);
    check("ram_inready_off", {31'd0, bus.in_ready}, 32'd0);

    // Reset in the middle of TX_DATA
    do_start(8'd2, 24'd9, 8'd0, 24'h0ABCDE);
    for (int i = 0; i < 5; i++) expect_out("rst_h", (i == 1) ? 8'h02 : ((i == 2) ? 8'h09 : 8'h00));
    expect_out("rst_d0", 8'hDE);
    expect_out("rst_d1", 8'hBD);
    snap = done_seen;
    #2 rstn = 1'b0;
    #1;
    check("arst_outvalid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_crc", crc, 32'hFFFFFFFF);
    check("arst_outdata", {24'd0, bus.out_data}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_done", done_seen - snap, 32'd0);
    do_start(8'd3, 24'd0, 8'hA5, 24'd0);
    expect_out("post_b0", 8'h00);
    expect_out("post_b1", 8'h03);
    expect_out("post_b2", 8'hA5);
    wait_done("post_done");
    check("post_pass", {31'd0, pass}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
